// File: rtl/uart_line_assembler.sv
// Pops bytes from the UART RX FIFO into a line buffer until a terminator (or idle timeout),
// then holds the completed line for a consumer via valid/ack and a registered read port.
module uart_line_assembler #(
    parameter int         MAX_LEN     = 64,
    parameter logic [7:0] TERM        = 8'h0A,
    parameter bit         STRIP_CR    = 1'b1,
    parameter int         TIMEOUT_CYC = 0,
    parameter int         LEN_W       = $clog2(MAX_LEN + 1),
    parameter int         AW          = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_empty,
    input  logic [7:0]       rx_data,
    output logic             rx_rd,
    output logic             line_valid,
    output logic [LEN_W-1:0] line_len,
    output logic             line_overflow,
    output logic             line_timeout,
    input  logic             line_ack,
    input  logic [AW-1:0]    rd_addr,
    output logic [7:0]       rd_data
);

    // The +2 keeps the idle counter at least one bit wide when the timeout is disabled.
    localparam int               IW      = $clog2(TIMEOUT_CYC + 2);
    localparam logic [IW-1:0]    TO_LIM  = IW'(TIMEOUT_CYC);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [7:0]       CR      = 8'h0D;

    typedef enum logic [1:0] {
        COLLECT,
        DISCARD,
        READY
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic             ovf_q, ovf_d;
    logic             to_q, to_d;
    logic             wr_en;
    logic             idle_tick;
    logic [7:0]       mem_q [MAX_LEN];
    logic [7:0]       rd_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= COLLECT;
            count_q <= '0;
            idle_q  <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idle_q  <= idle_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idle_d    = idle_q;
        ovf_d     = ovf_q;
        to_d      = to_q;
        wr_en     = 1'b0;
        idle_tick = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (rx_rd) begin
                    idle_d = '0;
                    if (rx_data == TERM) begin
                        if (count_q != '0) begin
                            state_d = READY;
                        end
                    end else if (STRIP_CR && (rx_data == CR)) begin
                        state_d = COLLECT;
                    end else if (count_q < LEN_MAX) begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end else if (count_q != '0) begin
                    idle_tick = 1'b1;
                end
            end
            DISCARD: begin
                if (rx_rd) begin
                    idle_d = '0;
                    if (rx_data == TERM) begin
                        state_d = READY;
                    end
                end else begin
                    idle_tick = 1'b1;
                end
            end
            READY: begin
                if (line_ack) begin
                    state_d = COLLECT;
                    count_d = '0;
                    idle_d  = '0;
                    ovf_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase

        // Flush fires on the edge where the counter would reach the limit.
        if (idle_tick && (TIMEOUT_CYC != 0)) begin
            if (idle_q + 1'b1 == TO_LIM) begin
                state_d = READY;
                to_d    = 1'b1;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_comb begin
        rx_rd         = !rx_empty && (state_q != READY);
        line_valid    = (state_q == READY);
        line_len      = (state_q == READY) ? count_q : '0;
        line_overflow = (state_q == READY) && ovf_q;
        line_timeout  = (state_q == READY) && to_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[count_q[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_uart_line_assembler.sv
// Directed bench for uart_line_assembler: a table of whole-line vectors plus hand-written
// sequences for backpressure, idle timeout, stray ack and asynchronous reset.
module tb_uart_line_assembler;

    typedef struct {
        logic [127:0] msg;
        int           n;
        bit           expValid;
        int           expLen;
        bit           expOvf;
        logic [63:0]  expBytes;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       rxEmpty;
    logic [7:0] rxData;
    logic       rxRd;
    logic       lineValid;
    logic [3:0] lineLen;
    logic       lineOverflow;
    logic       lineTimeout;
    logic       lineAck;
    logic [2:0] rdAddr;
    logic [7:0] rdData;

    logic       bEmpty;
    logic [7:0] bData;
    logic       bRd;
    logic       bValid;
    logic [6:0] bLen;
    logic       bOvf;
    logic       bTo;
    logic       bAck;
    logic [5:0] bAddr;
    logic [7:0] bRdData;

    logic [7:0] fifoQ[$];
    int         pops  = 0;
    int         total = 0;
    int         bad   = 0;
    vec_t       vecs[6];

    uart_line_assembler #(
        .MAX_LEN(8), .TERM(8'h0A), .STRIP_CR(1'b1), .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .reset_n(resetN), .rx_empty(rxEmpty), .rx_data(rxData), .rx_rd(rxRd),
        .line_valid(lineValid), .line_len(lineLen), .line_overflow(lineOverflow),
        .line_timeout(lineTimeout), .line_ack(lineAck), .rd_addr(rdAddr), .rd_data(rdData)
    );

    uart_line_assembler #(
        .MAX_LEN(64), .TERM(8'h0A), .STRIP_CR(1'b1), .TIMEOUT_CYC(0)
    ) dutNoTimeout (
        .clk(clk), .reset_n(resetN), .rx_empty(bEmpty), .rx_data(bData), .rx_rd(bRd),
        .line_valid(bValid), .line_len(bLen), .line_overflow(bOvf),
        .line_timeout(bTo), .line_ack(bAck), .rd_addr(bAddr), .rd_data(bRdData)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        rxEmpty = (fifoQ.size() == 0);
        rxData  = rxEmpty ? 8'h00 : fifoQ[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifoQ.push_back(b);
        refresh();
    endtask

    // One clock: the pop decision is the rx_rd seen at the edge, the FIFO model updates at the falling edge.
    task automatic tick();
        logic popped;
        @(posedge clk);
        popped = rxRd;
        @(negedge clk);
        if (popped) begin
            fifoQ.delete(0);
            pops++;
        end
        refresh();
    endtask

    task automatic waitValid(input string name);
        int k;
        k = 0;
        while (!lineValid && k < 60) begin
            tick();
            k++;
        end
        checkOutput(name, {31'b0, lineValid}, 32'd1);
    endtask

    task automatic readLine(input string name, input int len, input logic [63:0] bytes);
        for (int i = 0; i < len; i++) begin
            rdAddr = 3'(i);
            tick();
            checkOutput($sformatf("%s byte%0d", name, i), {24'b0, rdData}, {24'b0, bytes[8*(len-1-i) +: 8]});
        end
    endtask

    task automatic ackLine(input string name);
        lineAck = 1'b1;
        tick();
        lineAck = 1'b0;
        checkOutput({name, " ack valid"}, {31'b0, lineValid}, 32'd0);
        checkOutput({name, " ack len"}, {28'b0, lineLen}, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int    p0;
        string nm;
        nm = $sformatf("vec%0d", idx);
        p0 = pops;
        for (int i = 0; i < v.n; i++) begin
            push(v.msg[8*(v.n-1-i) +: 8]);
        end
        if (v.expValid) begin
            waitValid({nm, " valid"});
            checkOutput({nm, " len"}, {28'b0, lineLen}, 32'(v.expLen));
            checkOutput({nm, " ovf"}, {31'b0, lineOverflow}, {31'b0, v.expOvf});
            checkOutput({nm, " timeout"}, {31'b0, lineTimeout}, 32'd0);
            checkOutput({nm, " pops"}, 32'(pops - p0), 32'(v.n));
            checkOutput({nm, " fifo left"}, 32'(fifoQ.size()), 32'd0);
            readLine(nm, v.expLen, v.expBytes);
            ackLine(nm);
        end else begin
            repeat (v.n + 5) tick();
            checkOutput({nm, " no line"}, {31'b0, lineValid}, 32'd0);
            checkOutput({nm, " pops"}, 32'(pops - p0), 32'(v.n));
        end
    endtask

    initial begin
        int  p0;
        bit  seen;

        vecs[0] = '{msg: 128'("HELLO\n"), n: 6, expValid: 1'b1, expLen: 5, expOvf: 1'b0, expBytes: 64'("HELLO")};
        vecs[1] = '{msg: 128'("AB\015\n"), n: 4, expValid: 1'b1, expLen: 2, expOvf: 1'b0, expBytes: 64'("AB")};
        vecs[2] = '{msg: 128'("\n\n"), n: 2, expValid: 1'b0, expLen: 0, expOvf: 1'b0, expBytes: 64'h0};
        vecs[3] = '{msg: 128'("UUUUUUUUUUUU\n"), n: 13, expValid: 1'b1, expLen: 8, expOvf: 1'b1, expBytes: 64'("UUUUUUUU")};
        vecs[4] = '{msg: 128'("Q\015\015Z\n"), n: 5, expValid: 1'b1, expLen: 2, expOvf: 1'b0, expBytes: 64'("QZ")};
        vecs[5] = '{msg: 128'("12345678\n"), n: 9, expValid: 1'b1, expLen: 8, expOvf: 1'b0, expBytes: 64'("12345678")};

        resetN  = 1'b0;
        lineAck = 1'b0;
        rdAddr  = '0;
        bEmpty  = 1'b1;
        bData   = 8'h00;
        bAck    = 1'b0;
        bAddr   = '0;
        refresh();
        #1;
        checkOutput("reset valid", {31'b0, lineValid}, 32'd0);
        checkOutput("reset len", {28'b0, lineLen}, 32'd0);
        checkOutput("reset rd_data", {24'b0, rdData}, 32'd0);
        checkOutput("reset flags", {30'b0, lineOverflow, lineTimeout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Backpressure: second line must stay in the FIFO until the first is acked.
        p0 = pops;
        push("X"); push(8'h0A); push("Y"); push(8'h0A);
        waitValid("bp first valid");
        checkOutput("bp first pops", 32'(pops - p0), 32'd2);
        repeat (5) tick();
        checkOutput("bp fifo held", 32'(fifoQ.size()), 32'd2);
        checkOutput("bp rx_rd low", {31'b0, rxRd}, 32'd0);
        checkOutput("bp first len", {28'b0, lineLen}, 32'd1);
        readLine("bp first", 1, 64'("X"));
        ackLine("bp first");
        checkOutput("bp pop after ack", {31'b0, rxRd}, 32'd1);
        waitValid("bp second valid");
        checkOutput("bp second len", {28'b0, lineLen}, 32'd1);
        readLine("bp second", 1, 64'("Y"));
        ackLine("bp second");

        // Idle timeout: line appears exactly 100 idle edges after the last pop.
        p0 = pops;
        push("A"); push("B");
        tick();
        tick();
        checkOutput("to pops", 32'(pops - p0), 32'd2);
        repeat (99) tick();
        checkOutput("to not yet", {31'b0, lineValid}, 32'd0);
        tick();
        checkOutput("to valid", {31'b0, lineValid}, 32'd1);
        checkOutput("to flag", {31'b0, lineTimeout}, 32'd1);
        checkOutput("to len", {28'b0, lineLen}, 32'd2);
        checkOutput("to ovf", {31'b0, lineOverflow}, 32'd0);
        readLine("to", 2, 64'("AB"));
        ackLine("to");
        checkOutput("to flag cleared", {31'b0, lineTimeout}, 32'd0);

        // Ack while collecting must not disturb the partial line.
        push("H");
        tick();
        lineAck = 1'b1;
        tick();
        tick();
        lineAck = 1'b0;
        push("I"); push(8'h0A);
        waitValid("stray ack valid");
        checkOutput("stray ack len", {28'b0, lineLen}, 32'd2);
        readLine("stray ack", 2, 64'("HI"));
        ackLine("stray ack");

        // Asynchronous reset while a line is ready clears outputs without a clock edge.
        push("H"); push("E"); push(8'h0A);
        waitValid("rst ready valid");
        rdAddr = 3'd0;
        tick();
        checkOutput("rst pre rd_data", {24'b0, rdData}, 32'h48);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("rst async valid", {31'b0, lineValid}, 32'd0);
        checkOutput("rst async len", {28'b0, lineLen}, 32'd0);
        checkOutput("rst async rd_data", {24'b0, rdData}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        // Reset in the middle of a line discards the partial bytes.
        push("H"); push("E"); push("L");
        repeat (3) tick();
        #2;
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        push("O"); push("K"); push(8'h0A);
        waitValid("rst mid valid");
        checkOutput("rst mid len", {28'b0, lineLen}, 32'd2);
        readLine("rst mid", 2, 64'("OK"));
        ackLine("rst mid");

        // Timeout disabled: a partial line waits indefinitely.
        bEmpty = 1'b0;
        bData  = "A";
        @(negedge clk);
        bData  = "B";
        @(negedge clk);
        bEmpty = 1'b1;
        seen   = 1'b0;
        repeat (10000) begin
            @(negedge clk);
            if (bValid) seen = 1'b1;
        end
        checkOutput("no timeout", {31'b0, seen}, 32'd0);
        bEmpty = 1'b0;
        bData  = 8'h0A;
        @(negedge clk);
        bEmpty = 1'b1;
        checkOutput("no timeout valid", {31'b0, bValid}, 32'd1);
        checkOutput("no timeout len", {25'b0, bLen}, 32'd2);
        checkOutput("no timeout flag", {31'b0, bTo}, 32'd0);
        bAddr = 6'd1;
        @(negedge clk);
        checkOutput("no timeout byte1", {24'b0, bRdData}, 32'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_line_assembler.md
Name: uart_line_assembler

Overview:
Sits directly downstream of uart_top's RX FIFO. It pops received bytes and assembles them into a line buffer until the terminator byte arrives, then presents the completed line to a consumer (command parser / CPU port) through a valid/ack handshake and a random-access read port. It stalls the RX FIFO while a completed line is waiting to be read.

Parameters:
MAX_LEN, 64, line buffer depth in bytes (≥2)
TERM, 8'h0A, line terminator byte ('\n')
STRIP_CR, 1, when 1 byte 8'h0D is discarded and never stored
TIMEOUT_CYC, 0, idle clocks before a partial line is flushed; 0 disables the timeout
LEN_W, $clog2(MAX_LEN+1), line length width (derived, do not override)
AW, $clog2(MAX_LEN), read address width (derived)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
rx_empty  in  1  uart_top RX FIFO empty
rx_data  in  8  uart_top RX FIFO head byte, first-word-fall-through, valid while rx_empty=0
rx_rd  out  1  pop strobe to RX FIFO
line_valid  out  1  completed line available
line_len  out  LEN_W  number of stored bytes, terminator excluded
line_overflow  out  1  line exceeded MAX_LEN; excess bytes were dropped
line_timeout  out  1  line flushed by idle timeout, no terminator seen
line_ack  in  1  consumer releases the line
rd_addr  in  AW  line buffer read address
rd_data  out  8  line buffer byte, registered

Behaviour:
- Reset (async, reset_n=0): state COLLECT; count=0; line_valid=0, line_len=0, line_overflow=0, line_timeout=0, rd_data=0, idle counter=0.
- rx_rd is combinational: rx_rd = !rx_empty && state!=READY. A byte is consumed at the same clock edge where rx_rd=1.
- Each consumed byte in COLLECT is handled in this priority order:
  - TERM with count>0: go to READY. line_len=count.
  - TERM with count=0: dropped. Empty lines are never delivered.
  - 8'h0D with STRIP_CR=1: dropped.
  - count<MAX_LEN: buf[count]=byte; count++.
  - count==MAX_LEN: byte dropped; line_overflow=1; go to DISCARD.
- DISCARD: consumed bytes are dropped. TERM moves to READY with line_len=MAX_LEN and line_overflow=1.
- Timeout:
  - The idle counter clears on every consumed byte and on entry to COLLECT.
  - It increments each cycle with no pop while in COLLECT with count>0, or while in DISCARD.
  - When TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC, the block goes to READY with line_timeout=1, keeping line_len and line_overflow as they stand.
- READY:
  - line_valid=1 from the cycle after the terminating event.
  - rx_rd=0, so the FIFO backpressures.
  - line_ack=1 sampled in READY clears line_valid, line_len, line_overflow, line_timeout and count on that edge, and the state returns to COLLECT.
  - The next byte can be popped in the cycle immediately after the ack edge.
- line_ack outside READY is ignored.
- rd_data <= buf[rd_addr] every cycle, a 1-cycle read latency. The buffer contents stay stable while in READY. Data at rd_addr ≥ line_len is unspecified.
- Buffer write and rd_addr read in the same cycle at the same address return the old data. This case is not reachable while line_valid=1.
- Reset mid-line discards the partial line. Buffer RAM contents need not be cleared.
- line_len, line_overflow and line_timeout are meaningful only while line_valid=1; outside READY they read 0.

Test Plan:
1. Push "HELLO\n" into the FIFO model → rx_rd pulses 6 times; line_valid=1; line_len=5; rd_addr 0..4 gives 48,45,4C,4C,4F with 1-cycle latency; flags 0.
2. "AB\r\n" with STRIP_CR=1 → line_len=2, bytes 41,42. Then "\n\n" alone → no line_valid.
3. MAX_LEN=8, send 12×8'h55 then '\n' → line_len=8, line_overflow=1, all 8 bytes 55. The FIFO is left empty, showing excess bytes were consumed.
4. Backpressure: queue "X\nY\n" → after the first line, rx_rd stays 0 while line_valid=1, holding 2 bytes in the FIFO. Assert line_ack → the next line delivers line_len=1, byte 59.
5. TIMEOUT_CYC=100, send "AB" then nothing → line_valid rises 100 idle cycles after the last pop, with line_timeout=1 and line_len=2. With TIMEOUT_CYC=0 no line appears after 10000 cycles.
6. Drop reset_n low after 3 bytes of "HELLO" → all outputs go to 0 immediately, with no clock needed. After release, "OK\n" gives line_len=2, bytes 4F,4B.
